test_enum_rx: RTL and testbench

//  Receive end of the test-enum code stream: accepts 6-bit enum codes (X=10, A=30, B=41) on a

---
 rtl/test_enum_pkg.sv | 18 +
 rtl/test_enum_rx_sat_counter.sv | 26 ++
 rtl/test_enum_rx.sv | 118 +++++++++++
 tb/tb_test_enum_rx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_enum_pkg.sv
// Shared constants for the test-enum code stream: legal code values,
// the illegal-index marker and the receiver's processing states.
package test_enum_pkg;

    typedef logic [5:0] enum_code_t;

    localparam enum_code_t CODE_X      = 6'd10;
    localparam enum_code_t CODE_A      = 6'd30;
    localparam enum_code_t CODE_B      = 6'd41;
    localparam logic [1:0] IDX_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EMIT   = 2'd2
    } proc_state_t;

endpackage

// File: rtl/test_enum_rx_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (clr) begin
            q_reg <= '0;
        end else if (inc && (q_reg != {CNT_W{1'b1}})) begin
            q_reg <= q_reg + 1'b1;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/test_enum_rx.sv
// Receive end of the test-enum stream: one code in flight, decoded to index and
// one-hot, illegal codes flagged, per-code saturating counts kept.
module test_enum_rx
    import test_enum_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int CODE_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clr,
    output logic [1:0]        out_idx,
    output logic [2:0]        out_onehot,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  cnt_x,
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b,
    output logic [CNT_W-1:0]  cnt_err,
    output logic              err_sticky
);

    proc_state_t       state_reg, state_next;
    logic [CODE_W-1:0] code_reg;
    logic [1:0]        idx_reg;
    logic [2:0]        onehot_reg;
    logic              err_reg;
    logic              sticky_reg;

    logic [1:0]        dec_idx;
    logic [2:0]        dec_onehot;
    logic [3:0]        inc_vec;
    logic [CNT_W-1:0]  cnt_arr [4];

    // Exact compare only; everything else, including 0 and all-ones, is illegal.
    always_comb begin
        dec_idx = IDX_ILLEGAL;
        if (code_reg == CODE_W'(CODE_X)) begin
            dec_idx = 2'd0;
        end else if (code_reg == CODE_W'(CODE_A)) begin
            dec_idx = 2'd1;
        end else if (code_reg == CODE_W'(CODE_B)) begin
            dec_idx = 2'd2;
        end
        dec_onehot = (dec_idx == IDX_ILLEGAL) ? 3'b000 : (3'b001 << dec_idx);
        inc_vec    = (state_reg == ST_DECODE) ? (4'b0001 << dec_idx) : 4'b0000;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (in_valid) state_next = ST_DECODE;
            ST_DECODE: state_next = ST_EMIT;
            ST_EMIT:   if (out_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            code_reg   <= '0;
            idx_reg    <= 2'd0;
            onehot_reg <= 3'b000;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == ST_IDLE) && in_valid) begin
                code_reg <= in_code;
            end
            if (state_reg == ST_DECODE) begin
                idx_reg    <= dec_idx;
                onehot_reg <= dec_onehot;
                err_reg    <= (dec_idx == IDX_ILLEGAL);
            end
        end
    end

    // clr wins over a same-cycle illegal decode, matching the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_reg <= 1'b0;
        end else if (clr) begin
            sticky_reg <= 1'b0;
        end else if (inc_vec[3]) begin
            sticky_reg <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
            sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (inc_vec[gi]),
                .clr   (clr),
                .q     (cnt_arr[gi])
            );
        end
    endgenerate

    // Gating with rst_n keeps in_ready low while reset is held.
    assign in_ready   = rst_n && (state_reg == ST_IDLE);
    assign out_valid  = (state_reg == ST_EMIT);
    assign out_idx    = idx_reg;
    assign out_onehot = onehot_reg;
    assign out_err    = err_reg;
    assign err_sticky = sticky_reg;
    assign cnt_x      = cnt_arr[0];
    assign cnt_a      = cnt_arr[1];
    assign cnt_b      = cnt_arr[2];
    assign cnt_err    = cnt_arr[3];

endmodule

// File: tb/tb_test_enum_rx.sv
// Scoreboard bench for test_enum_rx: driver pushes expected results from a
// behavioural model, a negedge monitor pops and compares on each output handshake.
module tb_test_enum_rx;
    import test_enum_pkg::*;

    localparam int CNT_W = 2;
    localparam int SAT   = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [5:0]       in_code = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             clr = 1'b0;
    logic [1:0]       out_idx;
    logic [2:0]       out_onehot;
    logic             out_err;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] cnt_x, cnt_a, cnt_b, cnt_err;
    logic             err_sticky;

    logic rdy_dir = 1'b1;
    logic rdy_rand = 1'b1;
    logic rand_mode = 1'b0;
    assign out_ready = rand_mode ? rdy_rand : rdy_dir;

    test_enum_rx #(.CNT_W(CNT_W), .CODE_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid),
        .in_ready(in_ready), .clr(clr), .out_idx(out_idx), .out_onehot(out_onehot),
        .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
        .cnt_x(cnt_x), .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_err(cnt_err),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1 rdy_rand = ($urandom_range(0, 3) != 0);
    end

    typedef struct {
        int idx;
        int oh;
        int err;
        int c0, c1, c2, c3;
        int st;
        int hcyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   mc[4];
    int   ms = 0;
    int   last_h = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic int code_kind(input logic [5:0] c);
        if (c == 6'd10) return 0;
        if (c == 6'd30) return 1;
        if (c == 6'd41) return 2;
        return 3;
    endfunction

    // Monitor: latency is measured to the edge at which the consumer first samples out_valid.
    bit   seen = 1'b0;
    exp_t me;
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            seen = 1'b0;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", cyc + 1 - q[0].hcyc, 2);
                end
                if (out_ready) begin
                    me = q.pop_front();
                    seen = 1'b0;
                    $display("out idx=%0d onehot=%03b err=%0d cnt x/a/b/e=%0d/%0d/%0d/%0d sticky=%0d",
                             out_idx, out_onehot, out_err, cnt_x, cnt_a, cnt_b, cnt_err, err_sticky);
                    chk("out_idx", int'(out_idx), me.idx);
                    chk("out_onehot", int'(out_onehot), me.oh);
                    chk("out_err", int'(out_err), me.err);
                    chk("cnt_x", int'(cnt_x), me.c0);
                    chk("cnt_a", int'(cnt_a), me.c1);
                    chk("cnt_b", int'(cnt_b), me.c2);
                    chk("cnt_err", int'(cnt_err), me.c3);
                    chk("err_sticky", int'(err_sticky), me.st);
                end
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mc[i] = 0;
        ms = 0;
    endtask

    task automatic send(input logic [5:0] code, input bit clr_dec);
        int   k;
        exp_t e;
        bit   ok;
        ok = 1'b0;
        in_code  = code;
        in_valid = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("send_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        k = code_kind(code);
        mc[k] = (mc[k] < SAT) ? mc[k] + 1 : SAT;
        if (k == 3) ms = 1;
        if (clr_dec) model_clear();
        e.idx  = k;
        e.oh   = (k == 3) ? 0 : (1 << k);
        e.err  = (k == 3) ? 1 : 0;
        e.c0   = mc[0];
        e.c1   = mc[1];
        e.c2   = mc[2];
        e.c3   = mc[3];
        e.st   = ms;
        e.hcyc = cyc + 1;
        last_h = e.hcyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_code  = 6'($urandom);
        if (clr_dec) begin
            clr = 1'b1;
            @(posedge clk);
            #1 clr = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        model_clear();
        chk("clr_zero", int'({cnt_x, cnt_a, cnt_b, cnt_err, err_sticky}), 0);
    endtask

    int   h0, h1;
    logic [7:0] snap;

    initial begin
        model_clear();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_outs", int'({out_valid, out_idx, out_onehot, out_err, err_sticky}), 0);
        chk("rst_cnts", int'({cnt_x, cnt_a, cnt_b, cnt_err}), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single legal code, then a back-to-back stream with 3-clock spacing.
        send(6'd10, 1'b0);
        h0 = last_h;
        send(6'd10, 1'b0);
        chk("spacing_1", last_h - h0, 3);
        wait_drain();
        do_clr();
        send(6'd10, 1'b0);
        h0 = last_h;
        send(6'd41, 1'b0);
        h1 = last_h;
        chk("spacing_2", h1 - h0, 3);
        send(6'd30, 1'b0);
        chk("spacing_3", last_h - h1, 3);

        // Illegal code then a legal one: sticky must hold.
        send(6'd7, 1'b0);
        send(6'd30, 1'b0);
        wait_drain();
        chk("sticky_hold", int'(err_sticky), 1);

        // Stall in EMIT for 10 clocks.
        rdy_dir = 1'b0;
        send(6'd41, 1'b0);
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
        snap = {out_valid, in_ready, out_idx, out_onehot, out_err};
        chk("stall_enter", int'(snap), int'({1'b1, 1'b0, 2'd2, 3'b100, 1'b0}));
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("stall_hold", int'({out_valid, in_ready, out_idx, out_onehot, out_err}), int'(snap));
        end
        @(posedge clk);
        #1 rdy_dir = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stall_release", int'({out_valid, in_ready}), int'(2'b01));

        // Saturation of cnt_a and clr coincident with DECODE.
        wait_drain();
        do_clr();
        for (int i = 0; i < 5; i++) send(6'd30, 1'b0);
        wait_drain();
        chk("cnt_a_sat", int'(cnt_a), 3);
        send(6'd30, 1'b1);
        wait_drain();
        chk("cnt_a_clr_wins", int'(cnt_a), 0);

        // Async reset while a code is in DECODE.
        send(6'd7, 1'b0);
        wait_drain();
        send(6'd41, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", int'({out_valid, in_ready, out_idx, out_onehot, out_err, err_sticky}), 0);
        chk("rst_mid_cnts", int'({cnt_x, cnt_a, cnt_b, cnt_err}), 0);
        model_clear();
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(6'd41, 1'b0);
        wait_drain();

        // Randomized traffic with random backpressure and occasional clears.
        rand_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            int r;
            logic [5:0] c;
            r = $urandom_range(0, 9);
            if (r < 3)      c = 6'd10;
            else if (r < 5) c = 6'd30;
            else if (r < 7) c = 6'd41;
            else            c = 6'($urandom_range(0, 63));
            send(c, $urandom_range(0, 15) == 0);
            if (i % 25 == 24) begin
                wait_drain();
                do_clr();
            end
        end
        wait_drain();
        rand_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
